// File: rtl/nc_fetch_responder.sv
// Non-cacheable instruction fetch responder: reads one line as a series of
// bus-width memory beats and returns the packed line as a one-cycle pulse.
module nc_fetch_responder #(
  parameter int ICACHELINE_SIZE = 128,
  parameter int BUS_WIDTH       = 64,
  parameter int ADDR_SIZE       = 40
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       nc_fetch_req_valid_i,
  input  logic [ADDR_SIZE-1:0]       nc_fetch_req_addr_i,
  output logic                       nc_fetch_resp_valid_o,
  output logic [ICACHELINE_SIZE-1:0] nc_fetch_resp_data_o,
  output logic                       nc_fetch_resp_error_o,
  output logic                       mem_req_valid_o,
  input  logic                       mem_req_ready_i,
  output logic [ADDR_SIZE-1:0]       mem_req_addr_o,
  input  logic                       mem_rsp_valid_i,
  input  logic [BUS_WIDTH-1:0]       mem_rsp_data_i,
  input  logic                       mem_rsp_error_i
);

  localparam int NBEATS     = ICACHELINE_SIZE / BUS_WIDTH;
  localparam int LINE_BYTES = ICACHELINE_SIZE / 8;
  localparam int BUS_BYTES  = BUS_WIDTH / 8;
  localparam int BEAT_W     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  localparam logic [ADDR_SIZE-1:0] LINE_MASK = ~ADDR_SIZE'(LINE_BYTES - 1);
  localparam logic [ADDR_SIZE-1:0] BEAT_STEP = ADDR_SIZE'(BUS_BYTES);
  localparam logic [BEAT_W-1:0]    LAST_BEAT = BEAT_W'(NBEATS - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] REQ   = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] RESP  = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;

  logic [2:0]                 state_q, state_d;
  logic [BEAT_W-1:0]          beat_q, beat_d;
  logic [ADDR_SIZE-1:0]       addr_q, addr_d;
  logic [ICACHELINE_SIZE-1:0] line_q, line_d;
  logic                       err_q, err_d;
  logic                       mem_req_valid_q, mem_req_valid_d;
  logic                       resp_valid_q, resp_valid_d;

  // addr_q always holds base + beat*BUS_BYTES, so the beat address needs no multiplier.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    line_d  = line_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (nc_fetch_req_valid_i) begin
          addr_d  = nc_fetch_req_addr_i & LINE_MASK;
          beat_d  = '0;
          line_d  = '0;
          err_d   = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_req_ready_i) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_rsp_valid_i) begin
          line_d[int'(beat_q) * BUS_WIDTH +: BUS_WIDTH] = mem_rsp_data_i;
          if (mem_rsp_error_i) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else if (beat_q == LAST_BEAT) begin
            state_d = RESP;
          end else begin
            beat_d  = beat_q + BEAT_W'(1);
            addr_d  = addr_q + BEAT_STEP;
            state_d = REQ;
          end
        end
      end
      RESP: begin
        state_d = DRAIN;
      end
      DRAIN: begin
        // The requester holds valid until it sees the pulse; wait for it to drop.
        if (!nc_fetch_req_valid_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    mem_req_valid_d = (state_d == REQ);
    resp_valid_d    = (state_d == RESP);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      beat_q          <= '0;
      addr_q          <= '0;
      line_q          <= '0;
      err_q           <= 1'b0;
      mem_req_valid_q <= 1'b0;
      resp_valid_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      beat_q          <= beat_d;
      addr_q          <= addr_d;
      line_q          <= line_d;
      err_q           <= err_d;
      mem_req_valid_q <= mem_req_valid_d;
      resp_valid_q    <= resp_valid_d;
    end
  end

  assign mem_req_valid_o       = mem_req_valid_q;
  assign mem_req_addr_o        = addr_q;
  assign nc_fetch_resp_valid_o = resp_valid_q;
  assign nc_fetch_resp_data_o  = line_q;
  assign nc_fetch_resp_error_o = err_q;

endmodule

// File: tb/tb_nc_fetch_responder.sv
// Self-checking bench for nc_fetch_responder: a table of line fetches run
// through a small memory model and scoreboard, plus hand-written corner cases.
module tb_nc_fetch_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         req_valid;
  logic [39:0]  req_addr;
  logic         resp_valid;
  logic [127:0] resp_data;
  logic         resp_error;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [39:0]  mem_req_addr;
  logic         mem_rsp_valid;
  logic [63:0]  mem_rsp_data;
  logic         mem_rsp_error;

  logic         p1_req_valid;
  logic [39:0]  p1_req_addr;
  logic         p1_resp_valid;
  logic [63:0]  p1_resp_data;
  logic         p1_resp_error;
  logic         p1_mem_req_valid;
  logic         p1_mem_req_ready;
  logic [39:0]  p1_mem_req_addr;
  logic         p1_mem_rsp_valid;
  logic [63:0]  p1_mem_rsp_data;
  logic         p1_mem_rsp_error;

  nc_fetch_responder dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .nc_fetch_req_valid_i  (req_valid),
    .nc_fetch_req_addr_i   (req_addr),
    .nc_fetch_resp_valid_o (resp_valid),
    .nc_fetch_resp_data_o  (resp_data),
    .nc_fetch_resp_error_o (resp_error),
    .mem_req_valid_o       (mem_req_valid),
    .mem_req_ready_i       (mem_req_ready),
    .mem_req_addr_o        (mem_req_addr),
    .mem_rsp_valid_i       (mem_rsp_valid),
    .mem_rsp_data_i        (mem_rsp_data),
    .mem_rsp_error_i       (mem_rsp_error)
  );

  // Single-beat configuration: the line is exactly one bus word.
  nc_fetch_responder #(
    .ICACHELINE_SIZE (64),
    .BUS_WIDTH       (64),
    .ADDR_SIZE       (40)
  ) dut1 (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .nc_fetch_req_valid_i  (p1_req_valid),
    .nc_fetch_req_addr_i   (p1_req_addr),
    .nc_fetch_resp_valid_o (p1_resp_valid),
    .nc_fetch_resp_data_o  (p1_resp_data),
    .nc_fetch_resp_error_o (p1_resp_error),
    .mem_req_valid_o       (p1_mem_req_valid),
    .mem_req_ready_i       (p1_mem_req_ready),
    .mem_req_addr_o        (p1_mem_req_addr),
    .mem_rsp_valid_i       (p1_mem_rsp_valid),
    .mem_rsp_data_i        (p1_mem_rsp_data),
    .mem_rsp_error_i       (p1_mem_rsp_error)
  );

  typedef struct {
    logic [39:0]  addr;
    logic [39:0]  exp_base;
    logic [63:0]  beat0;
    logic [63:0]  beat1;
    logic         err0;
    logic         err1;
    int           stall;
    int           hold;
    logic [127:0] exp_data;
    logic         exp_err;
    int           exp_lat;
  } vec_t;

  typedef struct {
    logic [127:0] data;
    logic         err;
    int           cyc;
  } resp_t;

  vec_t         vecs[7];
  logic [39:0]  exp_addr_q[$];
  resp_t        exp_resp_q[$];

  int           errors;
  int           checks;
  int           cyc;
  int           acc_cnt;
  int           resp_cnt;
  int           stall_left;
  logic         mem_mute;
  logic         acc_seen;
  logic [39:0]  acc_addr;
  logic         prev_stall;
  logic [39:0]  prev_addr;
  logic         prev_resp;
  logic [39:0]  mem_base;
  logic [63:0]  mem_b0;
  logic [63:0]  mem_b1;
  logic         mem_e0;
  logic         mem_e1;

  // Every comparison in the bench funnels through here so the counts stay honest.
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name, input string detail);
    checks++;
    errors++;
    $display("[TB] FAIL %s: %s", name, detail);
  endtask

  // Mid-cycle monitor: memory handshakes are scored against the expected
  // address queue, response pulses against the expected response queue.
  task automatic checkOutput();
    resp_t r;
    if (prev_stall) begin
      check("req_valid_held", 128'(mem_req_valid), 128'(1));
      check("req_addr_stable", 128'(mem_req_addr), 128'(prev_addr));
    end
    prev_stall = mem_req_valid && !mem_req_ready;
    prev_addr  = mem_req_addr;
    if (mem_req_valid && mem_req_ready) begin
      acc_cnt++;
      acc_seen = 1'b1;
      acc_addr = mem_req_addr;
      if (exp_addr_q.size() == 0)
        failNow("unexpected_mem_req", $sformatf("got addr 0x%0h, expected no request", mem_req_addr));
      else
        check("mem_req_addr", 128'(mem_req_addr), 128'(exp_addr_q.pop_front()));
    end
    if (resp_valid) begin
      resp_cnt++;
      check("resp_single_cycle", 128'(prev_resp), 128'(0));
      if (exp_resp_q.size() == 0) begin
        failNow("unexpected_resp", $sformatf("got data 0x%0h, expected no response", resp_data));
      end else begin
        r = exp_resp_q.pop_front();
        check("resp_data", resp_data, r.data);
        check("resp_error", 128'(resp_error), 128'(r.err));
        check("resp_latency", 128'(cyc), 128'(r.cyc));
      end
    end
    prev_resp = resp_valid;
  endtask

  // Memory model: answers an accepted beat on the following cycle and can
  // hold ready low for a programmed number of cycles while a request waits.
  task automatic memModel();
    if (!mem_mute && acc_seen) begin
      mem_rsp_valid = 1'b1;
      if (acc_addr == mem_base) begin
        mem_rsp_data  = mem_b0;
        mem_rsp_error = mem_e0;
      end else if (acc_addr == mem_base + 40'd8) begin
        mem_rsp_data  = mem_b1;
        mem_rsp_error = mem_e1;
      end else begin
        mem_rsp_data  = 64'hBAD0_BAD0_BAD0_BAD0;
        mem_rsp_error = 1'b1;
      end
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = {$urandom, $urandom};
      mem_rsp_error = 1'($urandom_range(0, 1));
    end
    acc_seen = 1'b0;
    if (mem_req_valid && stall_left > 0) begin
      mem_req_ready = 1'b0;
      stall_left--;
    end else begin
      mem_req_ready = 1'b1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    checkOutput();
    cyc++;
    @(posedge clk);
    #1;
    memModel();
  endtask

  // Runs one line fetch: loads the memory image, queues the expected beat
  // addresses and response, then holds the request until the pulse is seen.
  task automatic applyStimulus(input vec_t v);
    int acc0;
    int target;
    acc0   = acc_cnt;
    target = resp_cnt + 1;
    mem_base   = v.exp_base;
    mem_b0     = v.beat0;
    mem_b1     = v.beat1;
    mem_e0     = v.err0;
    mem_e1     = v.err1;
    stall_left = v.stall;
    exp_addr_q.push_back(v.exp_base);
    if (!v.err0) exp_addr_q.push_back(v.exp_base + 40'd8);
    exp_resp_q.push_back('{v.exp_data, v.exp_err, cyc + v.exp_lat});
    req_valid = 1'b1;
    req_addr  = v.addr;
    for (int i = 0; i < 60 && resp_cnt < target; i++) begin
      tick();
      req_addr = 40'({$urandom, $urandom});
    end
    if (resp_cnt < target)
      failNow("resp_timeout", $sformatf("got no response for addr 0x%0h within 60 cycles", v.addr));
    check("beats_accepted", 128'(acc_cnt - acc0), 128'(v.err0 ? 1 : 2));
    for (int i = 0; i < v.hold; i++) tick();
    if (v.hold > 0)
      check("no_req_while_held", 128'(acc_cnt - acc0), 128'(v.err0 ? 1 : 2));
    req_valid = 1'b0;
    tick();
    tick();
    check("single_response", 128'(resp_cnt), 128'(target));
    check("addr_queue_empty", 128'(exp_addr_q.size()), 128'(0));
  endtask

  initial begin
    int acc0;
    int resp0;
    int p1_acc;
    logic p1_done;
    logic p1_pending;

    errors = 0; checks = 0; cyc = 0; acc_cnt = 0; resp_cnt = 0;
    stall_left = 0; mem_mute = 1'b0; acc_seen = 1'b0; acc_addr = '0;
    prev_stall = 1'b0; prev_addr = '0; prev_resp = 1'b0;
    mem_base = '0; mem_b0 = '0; mem_b1 = '0; mem_e0 = 1'b0; mem_e1 = 1'b0;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_error = 1'b0;
    p1_req_valid = 1'b0; p1_req_addr = '0; p1_mem_req_ready = 1'b0;
    p1_mem_rsp_valid = 1'b0; p1_mem_rsp_data = '0; p1_mem_rsp_error = 1'b0;

    vecs[0] = '{40'h80_0000_1234, 40'h80_0000_1230, 64'hAAAA_0000_0000_1111, 64'hBBBB_0000_0000_2222,
                1'b0, 1'b0, 0, 0, 128'hBBBB_0000_0000_2222_AAAA_0000_0000_1111, 1'b0, 5};
    vecs[1] = '{40'h00_0000_0040, 40'h00_0000_0040, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                1'b0, 1'b0, 4, 0, 128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF, 1'b0, 9};
    vecs[2] = '{40'h00_0000_2008, 40'h00_0000_2000, 64'h0000_0000_0000_DEAD, 64'h0000_0000_0000_9999,
                1'b1, 1'b0, 0, 0, 128'h0000_0000_0000_0000_0000_0000_0000_DEAD, 1'b1, 3};
    vecs[3] = '{40'h00_0000_0080, 40'h00_0000_0080, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0002,
                1'b0, 1'b0, 0, 6, 128'h0000_0000_0000_0002_0000_0000_0000_0001, 1'b0, 5};
    vecs[4] = '{40'h00_0000_1000, 40'h00_0000_1000, 64'h0000_0000_1000_0000, 64'h0000_0000_1008_0000,
                1'b0, 1'b0, 0, 0, 128'h0000_0000_1008_0000_0000_0000_1000_0000, 1'b0, 5};
    vecs[5] = '{40'h00_0000_300F, 40'h00_0000_3000, 64'h0000_0000_0000_0011, 64'h0000_0000_0000_0022,
                1'b0, 1'b1, 0, 0, 128'h0000_0000_0000_0022_0000_0000_0000_0011, 1'b1, 5};
    vecs[6] = '{40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFF0, 64'h0000_0000_0000_0005, 64'h0000_0000_0000_0006,
                1'b0, 1'b0, 0, 0, 128'h0000_0000_0000_0006_0000_0000_0000_0005, 1'b0, 5};

    // Reset state of both instances.
    repeat (2) @(posedge clk);
    #1;
    check("rst_resp_valid", 128'(resp_valid), 128'(0));
    check("rst_resp_data", resp_data, 128'(0));
    check("rst_resp_error", 128'(resp_error), 128'(0));
    check("rst_mem_req_valid", 128'(mem_req_valid), 128'(0));
    check("rst_mem_req_addr", 128'(mem_req_addr), 128'(0));
    check("rst_p1_resp_valid", 128'(p1_resp_valid), 128'(0));
    check("rst_p1_mem_req_valid", 128'(p1_mem_req_valid), 128'(0));
    rst = 1'b0;
    tick();
    tick();

    for (int i = 0; i < 7; i++) begin
      $display("[TB] vector %0d addr 0x%0h", i, vecs[i].addr);
      applyStimulus(vecs[i]);
    end

    // Reset while a beat is outstanding, then a stray response after release.
    $display("[TB] reset during WAIT");
    mem_mute = 1'b1;
    acc0  = acc_cnt;
    resp0 = resp_cnt;
    exp_addr_q.push_back(40'h500);
    req_valid = 1'b1;
    req_addr  = 40'h500;
    tick();
    tick();
    check("rstwait_accepted", 128'(acc_cnt - acc0), 128'(1));
    rst = 1'b1;
    req_valid = 1'b0;
    #1;
    check("rstwait_resp_valid", 128'(resp_valid), 128'(0));
    check("rstwait_resp_data", resp_data, 128'(0));
    check("rstwait_resp_error", 128'(resp_error), 128'(0));
    check("rstwait_mem_req_valid", 128'(mem_req_valid), 128'(0));
    check("rstwait_mem_req_addr", 128'(mem_req_addr), 128'(0));
    tick();
    rst = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'h0000_0000_0000_CAFE;
    mem_rsp_error = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("stray_no_resp", 128'(resp_cnt - resp0), 128'(0));
    check("stray_data_clear", resp_data, 128'(0));
    check("stray_no_mem_req", 128'(mem_req_valid), 128'(0));
    mem_mute = 1'b0;
    applyStimulus(vecs[0]);

    // Single-beat instance: unaligned address collapses to the line base.
    $display("[TB] single-beat line");
    p1_acc = 0;
    p1_done = 1'b0;
    p1_pending = 1'b0;
    p1_req_valid = 1'b1;
    p1_req_addr  = 40'h7;
    p1_mem_req_ready = 1'b1;
    for (int i = 0; i < 30 && !p1_done; i++) begin
      @(negedge clk);
      if (p1_mem_req_valid && p1_mem_req_ready) begin
        p1_acc++;
        p1_pending = 1'b1;
        check("p1_mem_req_addr", 128'(p1_mem_req_addr), 128'(0));
      end
      if (p1_resp_valid) begin
        p1_done = 1'b1;
        check("p1_resp_data", 128'(p1_resp_data), 128'(64'hC0FF_EE00_0000_0077));
        check("p1_resp_error", 128'(p1_resp_error), 128'(0));
      end
      @(posedge clk);
      #1;
      p1_mem_rsp_valid = p1_pending;
      p1_mem_rsp_data  = p1_pending ? 64'hC0FF_EE00_0000_0077 : 64'h0;
      p1_pending = 1'b0;
    end
    if (!p1_done) failNow("p1_resp_timeout", "got no response within 30 cycles");
    check("p1_beats_accepted", 128'(p1_acc), 128'(1));
    p1_req_valid = 1'b0;
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
